// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter family (up- and down-counters).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_pkg;

  // Controller state encoding, shared by every counter block in the family.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Default counter and load-value width.
  localparam int DEFAULT_CNT_WIDTH = 4;

endpackage

// File: rtl/down_count_reg.sv
// Down-count register: synchronous clear, parallel load, decrement on enable, saturating at zero.
// Latency: q updates on the posedge after a control input is presented; zero_next is combinational from q.
// Backpressure: none; control inputs are acted on every cycle.
module down_count_reg
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             zero_next
);

  // Reset has the highest priority, then clear, then load, then decrement.
  // The decrement is blocked at zero, so the count can never wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (dec && (q != '0)) begin
      q <= q - WIDTH'(1);
    end
  end

  // The next tick-qualified decrement takes the count to zero.
  assign zero_next = (q == WIDTH'(1));

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with a one-cycle done pulse; DOWN_COUNTER_AUTO_RELOAD_EN enables periodic reload.
// Latency: load of N>0 gives N tick-qualified COUNT cycles, then done for one cycle; N=0 goes straight to done.
// Backpressure: load_ready is high only in IDLE; loads offered at other times wait for load_ready.
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             tick,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] reload_reg;
  logic             reload_we;
  logic             cnt_clear;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_din;
  logic             cnt_dec;
  logic             zero_next;

  // Count storage lives in the sub-module; the FSM only steers its controls.
  down_count_reg #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear),
    .load      (cnt_load),
    .din       (cnt_din),
    .dec       (cnt_dec),
    .q         (q),
    .zero_next (zero_next)
  );

  // State register; reset mid-count returns to IDLE without a done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Remember the accepted start value so the count can be re-armed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      reload_reg <= '0;
    end else if (reload_we) begin
      reload_reg <= load_value;
    end
  end

  // Next-state and counter-control decode.
  always_comb begin
    state_nxt = state;
    reload_we = 1'b0;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_din   = load_value;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        // abort wins over a pending load: the handshake is not completed.
        if (load_valid && !abort) begin
          cnt_load  = 1'b1;
          reload_we = 1'b1;
          state_nxt = (load_value != '0) ? COUNT : DONE;
        end
      end
      COUNT: begin
        if (abort) begin
          cnt_clear = 1'b1;
          state_nxt = IDLE;
        end else if (tick) begin
          cnt_dec = 1'b1;
          if (zero_next) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        // Re-arm from the stored start value; abort or a zero period stops the cycle.
        if (abort || (reload_reg == '0)) begin
          state_nxt = IDLE;
        end else begin
          cnt_load  = 1'b1;
          cnt_din   = reload_reg;
          state_nxt = COUNT;
        end
`else
        // One-shot: always back to IDLE, abort is irrelevant here.
        state_nxt = IDLE;
`endif
      end
      default: begin
        cnt_clear = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
  // The stored start value is only consumed by the reload path.
  logic unused_reload;
  assign unused_reload = ^reload_reg;
`endif

  // Status outputs decode straight from the state register.
  assign load_ready = (state == IDLE);
  assign busy       = (state == COUNT);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

  localparam int W = 4;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] load_value;
  logic         load_ready;
  logic         tick;
  logic         abort;
  logic [W-1:0] q;
  logic         busy;
  logic         done;

  int total;
  int bad;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .tick       (tick),
    .abort      (abort),
    .q          (q),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check all four outputs in one go.
  task automatic chk_all(input string tag, input int eq, input bit eb, input bit ed, input bit er);
    chk({tag, ".q"},    32'(q),          32'(eq));
    chk({tag, ".busy"}, 32'(busy),       32'(eb));
    chk({tag, ".done"}, 32'(done),       32'(ed));
    chk({tag, ".rdy"},  32'(load_ready), 32'(er));
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b0;
    load_valid = 1'b0;
    load_value = '0;
    tick       = 1'b0;
    abort      = 1'b0;

    // Reset held two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'($urandom);
      load_value = W'($urandom);
      tick       = 1'($urandom);
      abort      = 1'($urandom);
      step();
    end
    chk_all("reset", 0, 0, 0, 1);
    reset      = 1'b1;
    load_valid = 1'b0;
    load_value = '0;
    tick       = 1'b0;
    abort      = 1'b0;
    step();
    chk_all("idle", 0, 0, 0, 1);

    // Basic count of 3 with tick held high; a load offered mid-count is ignored.
    load_valid = 1'b1;
    load_value = 4'd3;
    tick       = 1'b1;
    step();
    chk_all("basic3", 3, 1, 0, 0);
    load_value = 4'd7;
    step();
    chk_all("basic2", 2, 1, 0, 0);
    load_valid = 1'b0;
    step();
    chk_all("basic1", 1, 1, 0, 0);
    step();
    chk_all("basic_done", 0, 0, 1, 0);
    abort = AR;
    step();
    chk_all("basic_idle", 0, 0, 0, 1);
    abort = 1'b0;
    tick  = 1'b0;

    // Gapped ticks: load 5, alternate tick 1/0.
    load_valid = 1'b1;
    load_value = 4'd5;
    step();
    load_valid = 1'b0;
    chk_all("gap_load", 5, 1, 0, 0);
    for (int i = 4; i >= 0; i--) begin
      tick = 1'b1;
      step();
      if (i > 0) chk_all("gap_tick", i, 1, 0, 0);
      else       chk_all("gap_done", 0, 0, 1, 0);
      tick = 1'b0;
      if (i > 0) begin
        step();
        chk_all("gap_hold", i, 1, 0, 0);
      end
    end
    abort = AR;
    step();
    chk_all("gap_idle", 0, 0, 0, 1);
    abort = 1'b0;

    // Abort mid-count: load 9, two ticks, then abort together with tick.
    load_valid = 1'b1;
    load_value = 4'd9;
    tick       = 1'b1;
    step();
    load_valid = 1'b0;
    chk_all("ab_load", 9, 1, 0, 0);
    step();
    chk_all("ab_t1", 8, 1, 0, 0);
    step();
    chk_all("ab_t2", 7, 1, 0, 0);
    abort = 1'b1;
    step();
    chk_all("ab_abort", 0, 0, 0, 1);
    abort = 1'b0;
    tick  = 1'b0;
    step();
    chk_all("ab_nodone", 0, 0, 0, 1);

    // Abort in IDLE drops a concurrent load.
    load_valid = 1'b1;
    load_value = 4'd4;
    abort      = 1'b1;
    step();
    chk_all("ab_idle_drop", 0, 0, 0, 1);
    abort      = 1'b0;
    load_valid = 1'b0;

    // Zero load goes straight to DONE, then IDLE.
    load_valid = 1'b1;
    load_value = 4'd0;
    step();
    load_valid = 1'b0;
    chk_all("zero_done", 0, 0, 1, 0);
    step();
    chk_all("zero_idle", 0, 0, 0, 1);

    // Reset while counting at 6.
    load_valid = 1'b1;
    load_value = 4'd6;
    step();
    load_valid = 1'b0;
    chk_all("rst_cnt", 6, 1, 0, 0);
    reset = 1'b0;
    tick  = 1'b1;
    step();
    chk_all("rst_mid", 0, 0, 0, 1);
    reset = 1'b1;
    step();
    chk_all("rst_after", 0, 0, 0, 1);
    tick = 1'b0;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    // Periodic reload of 2: q runs 2,1,0,2,1,0 with done on every zero.
    load_valid = 1'b1;
    load_value = 4'd2;
    tick       = 1'b1;
    step();
    load_valid = 1'b0;
    for (int r = 0; r < 2; r++) begin
      chk_all("ar_q2", 2, 1, 0, 0);
      step();
      chk_all("ar_q1", 1, 1, 0, 0);
      step();
      chk_all("ar_done", 0, 0, 1, 0);
      if (r == 1) abort = 1'b1;
      step();
    end
    chk_all("ar_abort_idle", 0, 0, 0, 1);
    abort = 1'b0;
    tick  = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
